kalman: RTL and testbench

KALMAN -- requirements
Module: kalman

---
 rtl/kalman.sv | 206 ++++++++++++++++++++
 tb/tb_kalman.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kalman.sv
// Harmonic Kalman tracker: per run, form the innovation from the cascade input and z,
// update every harmonic state pair from Mem1 gains/rotations and stream results to Mem2.
module kalman #(
    parameter int DEBUG       = 0,
    parameter int N_HARM      = 4,
    parameter int MEM1_ADDR_W = 9
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [31:0]            Mem1_data_i,
    input  logic [MEM1_ADDR_W-1:0] Mem1_addrw_i,
    input  logic                   Mem1_clk_w,
    input  logic                   Mem1_clk_en_w,
    input  logic                   Mem1_we_i,
    input  logic                   enable_i,
    output logic [8:0]             Mem2_addrw_o,
    output logic [35:0]            Mem2_data_o,
    output logic                   Mem2_we_o,
    output logic                   WIP_flag_o,
    input  logic [53:0]            CIN,
    input  logic                   SIGNEDCIN,
    output logic [53:0]            CO,
    output logic                   SIGNEDCO
);

    localparam int KW = (N_HARM > 1) ? $clog2(N_HARM) : 1;
    localparam logic [KW-1:0] KLAST = KW'(N_HARM - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RDZ, S_ERR, S_COEF, S_WRX, S_WRE, S_WRD, S_DONE
    } state_t;

    state_t state, state_n;

    logic signed [31:0] mem1 [2**MEM1_ADDR_W];
    logic signed [31:0] rd_q;
    logic [MEM1_ADDR_W-1:0] rd_addr, ca;
    logic mem1_clk_q, en_q, start, mem1_wr;

    logic [KW-1:0] k, wk;
    logic [1:0]    ph;
    logic          wsel;

    logic signed [35:0] xc [N_HARM];
    logic signed [35:0] xs [N_HARM];
    logic signed [35:0] xn_c [N_HARM];
    logic signed [35:0] xn_s [N_HARM];
    logic signed [35:0] a_r [N_HARM];
    logic signed [35:0] b_r [N_HARM];
    logic signed [35:0] e_r, e_new, base, ab_new, xc_new, xs_new;
    logic signed [31:0] cos_r;
    logic signed [71:0] prod_k;
    logic [55:0]        sum;

    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [35:0] wr_data;

    function automatic logic signed [35:0] sat36(input logic signed [71:0] v);
        if (v[71:35] == '0 || v[71:35] == '1) return v[35:0];
        return v[71] ? 36'sh800000000 : 36'sh7FFFFFFFF;
    endfunction

    assign SIGNEDCO   = 1'b1;
    assign WIP_flag_o = (state != S_IDLE);
    assign start      = enable_i & ~en_q & (state == S_IDLE);
    assign mem1_wr    = Mem1_clk_w & ~mem1_clk_q & Mem1_clk_en_w & Mem1_we_i;

    // Read-first coefficient RAM: the registered read sees the pre-write word.
    always_ff @(posedge clk_i) begin
        if (mem1_wr) mem1[Mem1_addrw_i] <= Mem1_data_i;
        rd_q <= mem1[rd_addr];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem1_clk_q <= 1'b0;
            en_q       <= 1'b0;
            state      <= S_IDLE;
        end else begin
            mem1_clk_q <= Mem1_clk_w;
            en_q       <= enable_i;
            state      <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state)
            S_IDLE: if (start) state_n = S_RDZ;
            S_RDZ:  state_n = S_ERR;
            S_ERR: begin
                rd_addr = MEM1_ADDR_W'(1);
                state_n = S_COEF;
            end
            S_COEF: begin
                rd_addr = ca + MEM1_ADDR_W'(1);
                if (ph == 2'd3 && k == KLAST) state_n = S_WRX;
            end
            S_WRX: begin
                wr_en   = 1'b1;
                wr_addr = 9'({wk, wsel});
                wr_data = wsel ? xn_s[wk] : xn_c[wk];
                if (wsel && wk == KLAST) state_n = S_WRE;
            end
            S_WRE: begin
                wr_en   = 1'b1;
                wr_addr = 9'(2 * N_HARM);
                wr_data = e_r;
                state_n = (DEBUG != 0) ? S_WRD : S_DONE;
            end
            S_WRD: begin
                wr_en   = 1'b1;
                wr_addr = 9'd256 + 9'({wk, wsel});
                wr_data = wsel ? b_r[wk] : a_r[wk];
                if (wsel && wk == KLAST) state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        sum = SIGNEDCIN ? {{2{CIN[53]}}, CIN} : {2'b00, CIN};
        sum = sum + {{24{rd_q[31]}}, rd_q};
        for (int unsigned i = 0; i < N_HARM; i++) sum = sum - {{20{xc[i][35]}}, xc[i]};
        e_new  = sat36({{16{sum[55]}}, sum});
        // One multiplier serves the Kc phase (-> a) and the Ks phase (-> b).
        prod_k = 72'(rd_q) * 72'(e_r);
        base   = (ph == 2'd0) ? xc[k] : xs[k];
        ab_new = sat36(72'(base) + (prod_k >>> 30));
        xc_new = sat36((72'(cos_r) * 72'(a_r[k]) - 72'(rd_q) * 72'(b_r[k])) >>> 30);
        xs_new = sat36((72'(rd_q) * 72'(a_r[k]) + 72'(cos_r) * 72'(b_r[k])) >>> 30);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            Mem2_we_o    <= 1'b0;
            Mem2_addrw_o <= '0;
            Mem2_data_o  <= '0;
            CO           <= '0;
            e_r          <= '0;
            cos_r        <= '0;
            ca           <= '0;
            k            <= '0;
            ph           <= '0;
            wk           <= '0;
            wsel         <= 1'b0;
            for (int unsigned i = 0; i < N_HARM; i++) begin
                xc[i]   <= '0;
                xs[i]   <= '0;
                xn_c[i] <= '0;
                xn_s[i] <= '0;
                a_r[i]  <= '0;
                b_r[i]  <= '0;
            end
        end else begin
            Mem2_we_o <= wr_en;
            if (wr_en) begin
                Mem2_addrw_o <= wr_addr;
                Mem2_data_o  <= wr_data;
            end
            case (state)
                S_ERR: begin
                    e_r  <= e_new;
                    CO   <= sum[53:0];
                    ca   <= MEM1_ADDR_W'(1);
                    k    <= '0;
                    ph   <= '0;
                    wk   <= '0;
                    wsel <= 1'b0;
                end
                S_COEF: begin
                    ph <= ph + 2'd1;
                    ca <= ca + MEM1_ADDR_W'(1);
                    case (ph)
                        2'd0: a_r[k] <= ab_new;
                        2'd1: b_r[k] <= ab_new;
                        2'd2: cos_r  <= rd_q;
                        default: begin
                            xn_c[k] <= xc_new;
                            xn_s[k] <= xs_new;
                            if (k != KLAST) k <= k + KW'(1);
                        end
                    endcase
                end
                S_WRX, S_WRD: begin
                    wsel <= ~wsel;
                    if (wsel) wk <= (wk == KLAST) ? '0 : wk + KW'(1);
                end
                S_DONE: begin
                    for (int unsigned i = 0; i < N_HARM; i++) begin
                        xc[i] <= xn_c[i];
                        xs[i] <= xn_s[i];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kalman.sv
// Scoreboard bench for kalman: a big-integer reference model queues the expected Mem2
// writes of each run; monitors pop and compare them for a DEBUG=0 and a DEBUG=1 instance.
module tb_kalman;

    localparam int N   = 4;
    localparam int LIM = 8 * N + 16;

    typedef logic signed [127:0] big_t;
    typedef struct {
        logic [8:0]  addr;
        logic [35:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] Mem1_data_i = '0;
    logic [8:0]  Mem1_addrw_i = '0;
    logic        Mem1_clk_w = 1'b0, Mem1_clk_en_w = 1'b0, Mem1_we_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [53:0] CIN = '0;
    logic        SIGNEDCIN = 1'b0;

    logic [8:0]  addr0, addr1;
    logic [35:0] data0, data1;
    logic        we0, we1, wip0, wip1, sco0, sco1;
    logic [53:0] co0, co1;

    kalman #(.DEBUG(0), .N_HARM(N), .MEM1_ADDR_W(9)) dut (
        .clk_i(clk), .rst_i(rst_i), .Mem1_data_i(Mem1_data_i), .Mem1_addrw_i(Mem1_addrw_i),
        .Mem1_clk_w(Mem1_clk_w), .Mem1_clk_en_w(Mem1_clk_en_w), .Mem1_we_i(Mem1_we_i),
        .enable_i(enable_i), .Mem2_addrw_o(addr0), .Mem2_data_o(data0), .Mem2_we_o(we0),
        .WIP_flag_o(wip0), .CIN(CIN), .SIGNEDCIN(SIGNEDCIN), .CO(co0), .SIGNEDCO(sco0)
    );

    kalman #(.DEBUG(1), .N_HARM(N), .MEM1_ADDR_W(9)) dut_dbg (
        .clk_i(clk), .rst_i(rst_i), .Mem1_data_i(Mem1_data_i), .Mem1_addrw_i(Mem1_addrw_i),
        .Mem1_clk_w(Mem1_clk_w), .Mem1_clk_en_w(Mem1_clk_en_w), .Mem1_we_i(Mem1_we_i),
        .enable_i(enable_i), .Mem2_addrw_o(addr1), .Mem2_data_o(data1), .Mem2_we_o(we1),
        .WIP_flag_o(wip1), .CIN(CIN), .SIGNEDCIN(SIGNEDCIN), .CO(co1), .SIGNEDCO(sco1)
    );

    initial forever #5 clk = ~clk;

    wr_t         q0[$], q1[$];
    wr_t         w0, w1;
    logic [31:0] mm [512];
    big_t        xc_m[N], xs_m[N], xn_c_m[N], xn_s_m[N];
    logic [53:0] exp_co;
    logic [35:0] seen0 [512];
    int          n_cmp = 0, n_bad = 0;
    int          rises0 = 0, rises1 = 0;
    logic        wip0_q = 1'b0, wip1_q = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic big_t sat_m(input big_t v);
        big_t hi, lo;
        hi = (big_t'(1) <<< 35) - 1;
        lo = -(big_t'(1) <<< 35);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic big_t sx32(input logic [31:0] d);
        return {{96{d[31]}}, d};
    endfunction

    // Reference: one whole run in unbounded-precision arithmetic.
    task automatic model_run(input logic [53:0] cin, input bit sgn);
        big_t s, e, kc, ks, c, sn;
        big_t a[N], b[N];
        wr_t  w;
        s = sgn ? {{74{cin[53]}}, cin} : {74'b0, cin};
        s = s + sx32(mm[0]);
        for (int k = 0; k < N; k++) s = s - xc_m[k];
        exp_co = s[53:0];
        e = sat_m(s);
        for (int k = 0; k < N; k++) begin
            kc = sx32(mm[1 + 4 * k]);
            ks = sx32(mm[2 + 4 * k]);
            c  = sx32(mm[3 + 4 * k]);
            sn = sx32(mm[4 + 4 * k]);
            a[k] = sat_m(xc_m[k] + ((kc * e) >>> 30));
            b[k] = sat_m(xs_m[k] + ((ks * e) >>> 30));
            xn_c_m[k] = sat_m((c * a[k] - sn * b[k]) >>> 30);
            xn_s_m[k] = sat_m((sn * a[k] + c * b[k]) >>> 30);
        end
        for (int k = 0; k < N; k++) begin
            w.addr = 9'(2 * k);     w.data = xn_c_m[k][35:0]; q0.push_back(w); q1.push_back(w);
            w.addr = 9'(2 * k + 1); w.data = xn_s_m[k][35:0]; q0.push_back(w); q1.push_back(w);
        end
        w.addr = 9'(2 * N); w.data = e[35:0]; q0.push_back(w); q1.push_back(w);
        for (int k = 0; k < N; k++) begin
            w.addr = 9'(256 + 2 * k); w.data = a[k][35:0]; q1.push_back(w);
            w.addr = 9'(257 + 2 * k); w.data = b[k][35:0]; q1.push_back(w);
        end
    endtask

    always @(negedge clk) begin
        if (rst_i) begin
            wip0_q = 1'b0;
            wip1_q = 1'b0;
        end else begin
            if (wip0 && !wip0_q) rises0++;
            if (wip1 && !wip1_q) rises1++;
            wip0_q = wip0;
            wip1_q = wip1;
            if (we0) begin
                seen0[addr0] = data0;
                if (q0.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write0: got addr %0d data %0h, want no write", addr0, data0);
                end else begin
                    w0 = q0.pop_front();
                    chk("wr_addr0", 64'(addr0), 64'(w0.addr));
                    chk("wr_data0", 64'(data0), 64'(w0.data));
                end
            end
            if (we1) begin
                if (q1.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write1: got addr %0d data %0h, want no write", addr1, data1);
                end else begin
                    w1 = q1.pop_front();
                    chk("wr_addr1", 64'(addr1), 64'(w1.addr));
                    chk("wr_data1", 64'(data1), 64'(w1.data));
                end
            end
        end
    end

    task automatic m1_write(input int unsigned a, input logic [31:0] d, input bit we);
        Mem1_addrw_i = 9'(a);
        Mem1_data_i = d;
        Mem1_clk_en_w = 1'b1;
        Mem1_we_i = we;
        Mem1_clk_w = 1'b1;
        step(1);
        Mem1_clk_w = 1'b0;
        step(1);
        Mem1_clk_en_w = 1'b0;
        Mem1_we_i = 1'b0;
        if (we) mm[a] = d;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        q0.delete();
        q1.delete();
        for (int k = 0; k < N; k++) begin
            xc_m[k] = '0;
            xs_m[k] = '0;
        end
        step(2);
        chk("rst_wip", 64'(wip0 | wip1), 64'(0));
        chk("rst_we", 64'(we0 | we1), 64'(0));
        rst_i = 1'b0;
        step(1);
    endtask

    task automatic do_run(input logic [53:0] cin, input bit sgn, input bit hold);
        int t, len0, len1, r0, r1;
        for (int i = 0; i < 512; i++) seen0[i] = 'x;
        CIN = cin;
        SIGNEDCIN = sgn;
        model_run(cin, sgn);
        r0 = rises0;
        r1 = rises1;
        enable_i = 1'b1;
        t = 0;
        @(negedge clk);
        while (!wip0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("run_start", 64'(wip0), 64'(1));
        if (!hold) enable_i = 1'b0;
        len0 = 0; len1 = 0; t = 0;
        while ((wip0 || wip1) && t < 4 * LIM) begin
            if (wip0) len0++;
            if (wip1) len1++;
            if (hold && len0 == 5) enable_i = 1'b0;
            if (hold && len0 == 6) enable_i = 1'b1;
            @(negedge clk);
            t++;
        end
        chk("run_end", 64'(wip0 | wip1), 64'(0));
        chk("run_len0_in_budget", 64'(len0 > 0 && len0 <= LIM), 64'(1));
        chk("run_len1_in_budget", 64'(len1 > 0 && len1 <= LIM), 64'(1));
        if (hold) begin
            repeat (10) @(negedge clk);
            enable_i = 1'b0;
        end
        chk("runs_started0", 64'(rises0 - r0), 64'(1));
        chk("runs_started1", 64'(rises1 - r1), 64'(1));
        chk("co0", 64'(co0), 64'(exp_co));
        chk("co1", 64'(co1), 64'(exp_co));
        chk("pending0", 64'(q0.size()), 64'(0));
        chk("pending1", 64'(q1.size()), 64'(0));
        for (int k = 0; k < N; k++) begin
            xc_m[k] = xn_c_m[k];
            xs_m[k] = xn_s_m[k];
        end
        step(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] rv;
        logic [31:0] d;
        logic [53:0] cin;
        for (int k = 0; k < N; k++) begin
            xc_m[k] = '0;
            xs_m[k] = '0;
        end
        step(3);
        chk("reset_we", 64'(we0), 64'(0));
        chk("reset_addr", 64'(addr0), 64'(0));
        chk("reset_data", 64'(data0), 64'(0));
        chk("reset_co", 64'(co0), 64'(0));
        chk("reset_wip", 64'(wip0 | wip1), 64'(0));
        chk("signedco", 64'({sco0, sco1}), 64'(3));
        rst_i = 1'b0;
        step(1);

        for (int a = 0; a <= 4 * N; a++) m1_write(a, 32'd0, 1'b1);
        do_run(54'd0, 1'b0, 1'b0);
        chk("zero_co", 64'(co0), 64'(0));

        m1_write(0, 32'd1000, 1'b1);
        m1_write(1, 32'h40000000, 1'b1);
        m1_write(3, 32'h40000000, 1'b1);
        do_run(54'd0, 1'b0, 1'b0);
        chk("run1_addr0", 64'(seen0[0]), 64'(1000));
        chk("run1_addr8", 64'(seen0[8]), 64'(1000));
        do_run(54'd0, 1'b0, 1'b0);
        chk("run2_addr0", 64'(seen0[0]), 64'(1000));
        chk("run2_addr8", 64'(seen0[8]), 64'(0));

        do_reset();
        m1_write(3, 32'd0, 1'b1);
        m1_write(4, 32'h40000000, 1'b1);
        m1_write(0, 32'd77, 1'b0);
        do_run(54'd0, 1'b0, 1'b0);
        chk("rot_addr0", 64'(seen0[0]), 64'(0));
        chk("rot_addr1", 64'(seen0[1]), 64'(1000));
        chk("rot_addr8", 64'(seen0[8]), 64'(1000));

        do_reset();
        for (int a = 0; a <= 4 * N; a++) m1_write(a, 32'd0, 1'b1);
        do_run(54'h3F_FFFF_FFFF_FE0C, 1'b1, 1'b0);
        chk("signed_cin_e", 64'(seen0[8]), 64'(36'hF_FFFF_FE0C));
        chk("signed_cin_co", 64'(co0), 64'(54'h3F_FFFF_FFFF_FE0C));
        do_reset();
        do_run(54'h3F_FFFF_FFFF_FE0C, 1'b0, 1'b0);
        chk("unsigned_cin_sat", 64'(seen0[8]), 64'(36'h7_FFFF_FFFF));

        do_reset();
        m1_write(0, 32'd1000, 1'b1);
        m1_write(1, 32'h40000000, 1'b1);
        m1_write(4, 32'h40000000, 1'b1);
        do_run(54'd12345, 1'b0, 1'b1);

        model_run(54'd5, 1'b0);
        enable_i = 1'b1;
        step(1);
        enable_i = 1'b0;
        step(20);
        do_reset();
        repeat (40) @(negedge clk);
        chk("abort_idle", 64'(wip0 | wip1), 64'(0));
        step(1);

        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 5) == 0) do_reset();
            repeat ($urandom_range(1, 5)) begin
                d = $urandom;
                if ($urandom_range(0, 3) != 0) d = {{2{d[29]}}, d[29:0]};
                m1_write($urandom_range(0, 4 * N), d, 1'b1);
            end
            rv = {$urandom, $urandom};
            cin = rv[53:0];
            if ($urandom_range(0, 1) != 0) cin = {{32{rv[21]}}, rv[21:0]};
            do_run(cin, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
